ddr_app_arbiter: RTL

Two-client arbiter and sequencer for the MIG user (app_*) interface, in the ddr_ui_clk domain. Each client posts burst requests (write or read, base address, beat count). The block grants requests round-robin and issues one app command per beat, paces write data from the client's FWFT FIFO, and steers returned read data to the owning client through an in-order tag queue. It sits between the capture/readout DDR FSMs and the MIG core.

---
 rtl/ddr_arb_pkg.sv | 21 ++
 rtl/ddr_app_arbiter_if.sv | 26 ++
 rtl/ddr_arb_tag_fifo.sv | 47 ++++
 rtl/ddr_app_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared types for the MIG app-interface arbiter: FSM encoding, app_cmd codes
// and the read-tag record that ties returned read data to its client.
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_BURST = 2'd2
    } arb_state_t;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    localparam int TAG_LEN_W = 8;

    typedef struct packed {
        logic                 id;
        logic [TAG_LEN_W-1:0] len;
    } rd_tag_t;

endpackage

// File: rtl/ddr_app_arbiter_if.sv
// MIG user-interface command, write and read-return channel.
interface ddr_app_arbiter_if #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 256
);
    logic [ADDR_WIDTH-1:0] app_addr;
    logic [2:0]            app_cmd;
    logic                  app_en;
    logic [DATA_WIDTH-1:0] app_wdf_data;
    logic                  app_wdf_end;
    logic                  app_wdf_wren;
    logic                  app_rdy;
    logic                  app_wdf_rdy;
    logic [DATA_WIDTH-1:0] app_rd_data;
    logic                  app_rd_data_valid;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_wren,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_wren,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
endinterface

// File: rtl/ddr_arb_tag_fifo.sv
// In-order queue of outstanding read bursts; a push while full is accepted
// only when a pop frees the slot in the same cycle.
module ddr_arb_tag_fifo
    import ddr_arb_pkg::*;
#(
    parameter int TAG_DEPTH = 4
) (
    input  logic    ddr_ui_clk,
    input  logic    ddr_log_rst_n,
    input  logic    push,
    input  rd_tag_t push_tag,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output rd_tag_t head
);
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

    rd_tag_t          mem_reg [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (PTR_W+1)'(TAG_DEPTH));
    assign empty   = (count_reg == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem_reg[rd_ptr_reg];

    always_ff @(posedge ddr_ui_clk or negedge ddr_log_rst_n) begin
        if (!ddr_log_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
        end
    end

    always_ff @(posedge ddr_ui_clk) begin
        if (push_ok) mem_reg[wr_ptr_reg] <= push_tag;
    end
endmodule

// File: rtl/ddr_app_arbiter.sv
// Two-client round-robin burst sequencer for the MIG app interface, with
// write-data pacing and in-order steering of read data back to its client.
module ddr_app_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 256,
    parameter int LEN_W      = TAG_LEN_W,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                    ddr_ui_clk,
    input  logic                    ddr_log_rst_n,
    input  logic                    init_calib_complete,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_wr,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*LEN_W-1:0]      req_len,
    output logic [1:0]              req_ack,
    output logic [1:0]              req_done,
    input  logic [2*DATA_WIDTH-1:0] wr_data,
    output logic [1:0]              wr_rden,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [1:0]              rd_valid,
    output logic                    rd_last,
    output logic                    busy,
    output logic                    err_orphan,
    ddr_app_arbiter_if.master       app
);
    arb_state_t            state_reg, state_next;
    logic                  calib_reg;
    logic                  last_grant_reg, last_grant_next;
    logic                  id_reg, id_next;
    logic                  wr_reg, wr_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [LEN_W-1:0]      len_reg, len_next;
    logic [LEN_W-1:0]      beat_reg, beat_next;
    logic                  grant;
    logic                  app_en_c;
    logic                  wdf_wren;
    logic [1:0]            elig;
    logic                  tag_push, tag_pop, tag_full, tag_empty, tag_room;
    rd_tag_t               tag_push_data, tag_head;

    logic [ADDR_WIDTH-1:0] req_addr_arr [2];
    logic [LEN_W-1:0]      req_len_arr  [2];
    logic [DATA_WIDTH-1:0] wr_data_arr  [2];

    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic [1:0]            rd_valid_reg;
    logic                  rd_last_reg;
    logic [LEN_W-1:0]      rd_beat_reg;
    logic                  err_orphan_reg;
    logic                  rd_beat_last;

    // A pop in this cycle frees a slot before eligibility is judged.
    assign tag_room = ~tag_full | tag_pop;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_client
            assign req_addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign req_len_arr[gi]  = req_len[gi*LEN_W +: LEN_W];
            assign wr_data_arr[gi]  = wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign elig[gi]         = req_valid[gi] & (req_wr[gi] | tag_room);
            assign wr_rden[gi]      = wdf_wren & (id_reg == 1'(gi));
        end
    endgenerate

    always_ff @(posedge ddr_ui_clk or negedge ddr_log_rst_n) begin
        if (!ddr_log_rst_n) begin
            state_reg      <= ST_IDLE;
            calib_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            id_reg         <= 1'b0;
            wr_reg         <= 1'b0;
            addr_reg       <= '0;
            len_reg        <= '0;
            beat_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            calib_reg      <= init_calib_complete;
            last_grant_reg <= last_grant_next;
            id_reg         <= id_next;
            wr_reg         <= wr_next;
            addr_reg       <= addr_next;
            len_reg        <= len_next;
            beat_reg       <= beat_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        id_next         = id_reg;
        wr_next         = wr_reg;
        addr_next       = addr_reg;
        len_next        = len_reg;
        beat_next       = beat_reg;
        grant           = 1'b0;
        req_ack         = '0;
        req_done        = '0;
        tag_push        = 1'b0;
        tag_push_data   = '0;
        app_en_c        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (calib_reg) state_next = ST_ARB;
            end
            ST_ARB: begin
                if (!calib_reg) begin
                    state_next = ST_IDLE;
                end else if (|elig) begin
                    grant          = (elig == 2'b11) ? ~last_grant_reg : elig[1];
                    req_ack[grant] = 1'b1;
                    id_next        = grant;
                    wr_next        = req_wr[grant];
                    addr_next      = req_addr_arr[grant];
                    len_next       = req_len_arr[grant];
                    beat_next      = '0;
                    if (req_len_arr[grant] == '0) begin
                        req_done[grant] = 1'b1;
                        last_grant_next = grant;
                    end else begin
                        state_next = ST_BURST;
                        if (!req_wr[grant]) begin
                            tag_push          = 1'b1;
                            tag_push_data.id  = grant;
                            tag_push_data.len = req_len_arr[grant];
                        end
                    end
                end
            end
            ST_BURST: begin
                app_en_c = wr_reg ? (app.app_wdf_rdy & app.app_rdy) : app.app_rdy;
                if (app_en_c) begin
                    addr_next = addr_reg + ADDR_WIDTH'(8);
                    beat_next = beat_reg + LEN_W'(1);
                    if (beat_reg == len_reg - LEN_W'(1)) begin
                        req_done[id_reg] = 1'b1;
                        last_grant_next  = id_reg;
                        state_next       = ST_ARB;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign wdf_wren         = app_en_c & wr_reg;
    assign app.app_en       = app_en_c;
    assign app.app_addr     = (state_reg == ST_BURST) ? addr_reg : '0;
    assign app.app_cmd      = (state_reg == ST_BURST && !wr_reg) ? CMD_RD : CMD_WR;
    assign app.app_wdf_wren = wdf_wren;
    assign app.app_wdf_end  = wdf_wren;
    assign app.app_wdf_data = (state_reg == ST_BURST && wr_reg) ? wr_data_arr[id_reg] : '0;
    assign busy             = (state_reg == ST_BURST) | ~tag_empty;

    ddr_arb_tag_fifo #(.TAG_DEPTH(TAG_DEPTH)) u_tag_fifo (
        .ddr_ui_clk    (ddr_ui_clk),
        .ddr_log_rst_n (ddr_log_rst_n),
        .push          (tag_push),
        .push_tag      (tag_push_data),
        .pop           (tag_pop),
        .full          (tag_full),
        .empty         (tag_empty),
        .head          (tag_head)
    );

    // The tag retires on its final beat, as that beat enters the output register.
    assign rd_beat_last = (rd_beat_reg == tag_head.len - LEN_W'(1));
    assign tag_pop      = app.app_rd_data_valid & ~tag_empty & rd_beat_last;

    always_ff @(posedge ddr_ui_clk or negedge ddr_log_rst_n) begin
        if (!ddr_log_rst_n) begin
            rd_valid_reg   <= '0;
            rd_last_reg    <= 1'b0;
            rd_beat_reg    <= '0;
            err_orphan_reg <= 1'b0;
        end else begin
            rd_valid_reg <= '0;
            rd_last_reg  <= 1'b0;
            if (app.app_rd_data_valid) begin
                if (tag_empty) begin
                    err_orphan_reg <= 1'b1;
                end else begin
                    rd_valid_reg <= tag_head.id ? 2'b10 : 2'b01;
                    rd_last_reg  <= rd_beat_last;
                    rd_beat_reg  <= rd_beat_last ? '0 : rd_beat_reg + LEN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge ddr_ui_clk) begin
        if (app.app_rd_data_valid) rd_data_reg <= app.app_rd_data;
    end

    assign rd_data    = rd_data_reg;
    assign rd_valid   = rd_valid_reg;
    assign rd_last    = rd_last_reg;
    assign err_orphan = err_orphan_reg;
endmodule
